// File: rtl/ising_run_ctrl_pkg.sv
// rtl/ising_run_ctrl_pkg.sv - shared address map, register offsets and state encodings for the run controller
package ising_run_ctrl_pkg;

    localparam logic [7:0] CTRL_ADDR_MASK   = 8'h42;
    localparam logic [7:0] WEIGHT_ADDR_MASK = 8'h41;

    localparam logic [11:0] OFF_CTRL       = 12'h000;
    localparam logic [11:0] OFF_RUN_CYCLES = 12'h004;
    localparam logic [11:0] OFF_STATUS     = 12'h008;
    localparam logic [11:0] OFF_SPINS      = 12'h00C;
    localparam logic [11:0] OFF_AGREE_BASE = 12'h100;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RESET  = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef struct packed {
        logic abort;
        logic start;
    } ctrl_cmd_t;

    function automatic logic [11:0] agree_offset(input int idx);
        return OFF_AGREE_BASE + 12'(idx * 4);
    endfunction

    function automatic logic addr_hit(input logic [31:0] addr);
        return addr[31:24] == CTRL_ADDR_MASK;
    endfunction

endpackage

// File: rtl/phase_agree_counter.sv
// rtl/phase_agree_counter.sv - per-oscillator saturating agree counter with spin decision latch
module phase_agree_counter #(
    parameter int CNT_W         = 32,
    parameter int SAMPLE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             latch,
    input  logic             osc_bit,
    input  logic             ref_bit,
    output logic [CNT_W-1:0] agree,
    output logic             spin
);

    logic [CNT_W-1:0] agree_nxt;

    always_comb begin
        agree_nxt = agree;
        if (enable && (osc_bit == ref_bit) && (agree != '1))
            agree_nxt = agree + CNT_W'(1);
    end

    // The decision uses agree_nxt so the final window cycle is counted.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            agree <= '0;
            spin  <= 1'b0;
        end else begin
            agree <= agree_nxt;
            if (latch)
                spin <= {agree_nxt, 1'b0} > (CNT_W+1)'(SAMPLE_CYCLES);
        end
    end

endmodule

// File: rtl/ising_run_ctrl.sv
// rtl/ising_run_ctrl.sv - sequences reset, run and phase sampling of the oscillator matrix
module ising_run_ctrl
    import ising_run_ctrl_pkg::*;
#(
    parameter int N             = 8,
    parameter int RST_CYCLES    = 16,
    parameter int SAMPLE_CYCLES = 1024,
    parameter int CNT_W         = 32
) (
    input  logic          clk,
    input  logic          axi_rst,
    input  logic          wready,
    input  logic [31:0]   wr_addr,
    input  logic [31:0]   wdata,
    input  logic [31:0]   rd_addr,
    output logic [31:0]   rdata,
    input  logic [N-1:0]  osc_outputs,
    output logic          ising_rstn,
    output logic          busy,
    output logic          done
);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] run_cycles;
    logic [CNT_W-1:0] run_len;
    logic [N-1:0]     sync1;
    logic [N-1:0]     sync2;
    logic [N-1:0]     spins;
    logic [CNT_W-1:0] agree [N];
    logic [31:0]      rd_nxt;
    logic [11:0]      wr_off;
    logic [11:0]      rd_off;
    logic             wr_hit;
    ctrl_cmd_t        cmd;
    logic             start_acc;
    logic             sample_en;
    logic             sample_last;
    logic             unused_addr_bits;

    assign unused_addr_bits = &{1'b0, wr_addr[23:12], rd_addr[23:12]};

    assign wr_off    = wr_addr[11:0];
    assign rd_off    = rd_addr[11:0];
    assign wr_hit    = wready && addr_hit(wr_addr);
    assign cmd.start = wr_hit && (wr_off == OFF_CTRL) && wdata[0];
    assign cmd.abort = wr_hit && (wr_off == OFF_CTRL) && wdata[1];

    assign start_acc   = cmd.start && !cmd.abort && ((state == ST_IDLE) || (state == ST_DONE));
    assign sample_en   = (state == ST_SAMPLE) && !cmd.abort;
    assign sample_last = sample_en && (cnt == CNT_W'(SAMPLE_CYCLES - 1));
    assign cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    assign ising_rstn = (state == ST_RUN) || (state == ST_SAMPLE);
    assign busy       = (state == ST_RESET) || (state == ST_RUN) || (state == ST_SAMPLE);
    assign done       = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (axi_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= osc_outputs;
            sync2 <= sync1;
        end
    end

    // Oscillator 0 is compared with itself, so its spin always resolves to 1.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_agree
            phase_agree_counter #(
                .CNT_W         (CNT_W),
                .SAMPLE_CYCLES (SAMPLE_CYCLES)
            ) u_agree (
                .clk     (clk),
                .rst     (axi_rst),
                .clear   (start_acc),
                .enable  (sample_en),
                .latch   (sample_last),
                .osc_bit (sync2[gi]),
                .ref_bit (sync2[0]),
                .agree   (agree[gi]),
                .spin    (spins[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (axi_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            run_cycles <= '0;
            run_len    <= '0;
        end else begin
            if (wr_hit && (wr_off == OFF_RUN_CYCLES))
                run_cycles <= wdata[CNT_W-1:0];
            if (cmd.abort) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start_acc) begin
                            state   <= ST_RESET;
                            cnt     <= '0;
                            run_len <= run_cycles;
                        end
                    end
                    ST_RESET: begin
                        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                            cnt   <= '0;
                            state <= (run_len == '0) ? ST_SAMPLE : ST_RUN;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_RUN: begin
                        if (cnt_inc >= run_len) begin
                            cnt   <= '0;
                            state <= ST_SAMPLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_SAMPLE: begin
                        if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
                            cnt   <= '0;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rd_nxt = '0;
        if (addr_hit(rd_addr)) begin
            case (rd_off)
                OFF_RUN_CYCLES: rd_nxt = 32'(run_cycles);
                OFF_STATUS:     rd_nxt = {27'd0, done, busy, state};
                OFF_SPINS:      rd_nxt = 32'(spins);
                default: begin
                    for (int i = 0; i < N; i++) begin
                        if (rd_off == agree_offset(i))
                            rd_nxt = 32'(agree[i]);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (axi_rst)
            rdata <= '0;
        else
            rdata <= rd_nxt;
    end

endmodule

// File: tb/tb_ising_run_ctrl.sv
// tb/tb_ising_run_ctrl.sv - randomized self-checking bench for ising_run_ctrl
module tb_ising_run_ctrl;
    import ising_run_ctrl_pkg::*;

    localparam int N      = 8;
    localparam int RST    = 16;
    localparam int SMP    = 1024;
    localparam int LOGLEN = 32768;

    logic          clk = 1'b0;
    logic          axi_rst;
    logic          wready;
    logic [31:0]   wr_addr;
    logic [31:0]   wdata;
    logic [31:0]   rd_addr;
    logic [31:0]   rdata;
    logic [N-1:0]  osc_outputs;
    logic          ising_rstn;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    ising_run_ctrl #(
        .N(N), .RST_CYCLES(RST), .SAMPLE_CYCLES(SMP), .CNT_W(32)
    ) dut (
        .clk(clk), .axi_rst(axi_rst), .wready(wready), .wr_addr(wr_addr),
        .wdata(wdata), .rd_addr(rd_addr), .rdata(rdata), .osc_outputs(osc_outputs),
        .ising_rstn(ising_rstn), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Log of the oscillator value present at each rising edge, indexed by edge number.
    int           cyc = 0;
    logic [N-1:0] osc_log [LOGLEN];
    always @(posedge clk) begin
        if (cyc < LOGLEN) osc_log[cyc] <= osc_outputs;
        cyc <= cyc + 1;
    end

    int   mode = 0;
    int   p_agree [N];
    logic phase = 1'b0;
    always @(negedge clk) begin
        logic [N-1:0] v;
        phase = ~phase;
        v = '0;
        if (mode == 0) begin
            v[0] = phase;
            v[1] = phase;
            v[2] = ~phase;
            v[3] = 1'b0;
            for (int i = 4; i < N; i++) v[i] = phase ^ (int'($urandom_range(0, 99)) >= p_agree[i]);
        end else begin
            v[0] = 1'($urandom_range(0, 1));
            for (int i = 1; i < N; i++) v[i] = v[0] ^ (int'($urandom_range(0, 99)) >= p_agree[i]);
        end
        osc_outputs = v;
    end

    int last_wr_edge;
    int w_edge;
    int n_lo, n_hi, n_busy;
    int exp_agree [N];
    logic [31:0] exp_spins;

    task automatic wr(input logic [11:0] off, input logic [31:0] d);
        wready  = 1'b1;
        wr_addr = {CTRL_ADDR_MASK, 12'h000, off};
        wdata   = d;
        @(posedge clk);
        last_wr_edge = cyc;
        @(negedge clk);
        wready = 1'b0;
    endtask

    task automatic rd_raw(input logic [31:0] addr, output logic [31:0] v);
        rd_addr = addr;
        @(posedge clk);
        @(negedge clk);
        v = rdata;
    endtask

    task automatic rd(input logic [11:0] off, output logic [31:0] v);
        rd_raw({CTRL_ADDR_MASK, 12'h000, off}, v);
    endtask

    // kind: 0 none, 1 start write, 2 RUN_CYCLES write, 3 start+abort, 4 axi_rst pulse
    task automatic run(input int kind, input int at, input logic [31:0] val);
        int t;
        bit injected;
        rd_addr = {CTRL_ADDR_MASK, 12'h000, OFF_STATUS};
        wr(OFF_CTRL, 32'h1);
        w_edge = last_wr_edge;
        n_lo = 0; n_hi = 0; n_busy = 0; t = 0; injected = 0;
        while (busy && t < 4000) begin
            n_busy++;
            if (!ising_rstn) n_lo++;
            else n_hi++;
            if (kind != 0 && !injected && n_hi == at) begin
                injected = 1;
                case (kind)
                    1: wr(OFF_CTRL, 32'h1);
                    2: wr(OFF_RUN_CYCLES, val);
                    3: wr(OFF_CTRL, 32'h3);
                    default: begin
                        axi_rst = 1'b1;
                        @(posedge clk);
                        @(negedge clk);
                        axi_rst = 1'b0;
                    end
                endcase
            end else begin
                @(negedge clk);
            end
            t++;
        end
        if (t >= 4000) check("run_timeout", 32'd0, 32'd1);
    endtask

    // Agree window: comparisons see the oscillator value two edges late through the synchronizer.
    task automatic model(input int r);
        int s;
        s = w_edge + RST + r;
        exp_spins = '0;
        for (int i = 0; i < N; i++) begin
            exp_agree[i] = 0;
            for (int k = s - 1; k < s - 1 + SMP; k++)
                if (osc_log[k][i] == osc_log[k][0]) exp_agree[i]++;
            exp_spins[i] = (2 * exp_agree[i] > SMP);
        end
        exp_spins[0] = 1'b1;
    endtask

    task automatic check_results(input int r);
        logic [31:0] v;
        model(r);
        for (int i = 0; i < N; i++) begin
            rd(agree_offset(i), v);
            check($sformatf("agree%0d", i), v, 32'(exp_agree[i]));
        end
        rd(OFF_SPINS, v);
        check("spins", v, exp_spins);
    endtask

    task automatic check_timing(input string tag, input int r);
        check({tag, "_rst_lo"}, 32'(n_lo), 32'(RST));
        check({tag, "_rstn_hi"}, 32'(n_hi), 32'(r + SMP));
        check({tag, "_busy"}, 32'(n_busy), 32'(RST + r + SMP));
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_rstn_done"}, {31'd0, ising_rstn}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int r;
        axi_rst = 1'b1; wready = 1'b0; wr_addr = '0; wdata = '0; rd_addr = '0;
        for (int i = 0; i < N; i++) p_agree[i] = int'($urandom_range(0, 100));
        repeat (4) @(negedge clk);
        axi_rst = 1'b0;

        check("rst_rstn", {31'd0, ising_rstn}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rd(OFF_STATUS, v);      check("rst_status", v, 32'h0);
        rd(OFF_SPINS, v);       check("rst_spins", v, 32'h0);
        rd(agree_offset(3), v); check("rst_agree3", v, 32'h0);

        // Run A: plan pattern, RUN_CYCLES=100, ignored start mid-run.
        mode = 0;
        wr(OFF_RUN_CYCLES, 32'd100);
        run(1, 30, 32'd0);
        check_timing("a", 100);
        rd(OFF_STATUS, v); check("a_status", v, 32'h14);
        check_results(100);
        rd(agree_offset(1), v); check("a_agree1_const", v, 32'd1024);
        rd(agree_offset(2), v); check("a_agree2_const", v, 32'd0);
        rd(agree_offset(3), v); check("a_agree3_const", v, 32'd512);
        rd(OFF_SPINS, v);
        check("a_spins_low4", {28'd0, v[3:0]}, 32'h3);
        rd_raw({8'h00, 12'h000, agree_offset(1)}, v); check("a_unmapped", v, 32'h0);
        rd(12'h102, v); check("a_unaligned", v, 32'h0);
        rd(OFF_CTRL, v); check("a_ctrl_reads0", v, 32'h0);

        // Run B: random phases, no RUN phase at all.
        mode = 1;
        for (int i = 0; i < N; i++) p_agree[i] = int'($urandom_range(0, 100));
        wr(OFF_RUN_CYCLES, 32'd0);
        run(0, 0, 32'd0);
        check_timing("b", 0);
        check_results(0);

        // Run C: abort (together with start) on RUN cycle 50.
        wr(OFF_RUN_CYCLES, 32'd100);
        run(3, 50, 32'd0);
        check("c_rst_lo", 32'(n_lo), 32'(RST));
        check("c_run_len", 32'(n_hi), 32'd50);
        check("c_rstn", {31'd0, ising_rstn}, 32'd0);
        check("c_busy", {31'd0, busy}, 32'd0);
        rd(OFF_STATUS, v); check("c_status", v, 32'h0);

        // Run D: random RUN_CYCLES, rewritten mid-run without effect on this run.
        for (int i = 0; i < N; i++) p_agree[i] = int'($urandom_range(0, 100));
        r = int'($urandom_range(20, 200));
        wr(OFF_RUN_CYCLES, 32'(r));
        run(2, 10, 32'd7);
        check_timing("d", r);
        check_results(r);
        rd(OFF_RUN_CYCLES, v); check("d_run_cycles", v, 32'd7);

        // Run E: new RUN_CYCLES applies; axi_rst mid-SAMPLE clears everything.
        run(4, 7 + 500, 32'd0);
        check("e_rstn_hi", 32'(n_hi), 32'd507);
        check("e_busy", {31'd0, busy}, 32'd0);
        check("e_done", {31'd0, done}, 32'd0);
        check("e_rstn", {31'd0, ising_rstn}, 32'd0);
        check("e_rdata", rdata, 32'h0);
        rd(OFF_RUN_CYCLES, v);  check("e_run_cycles", v, 32'h0);
        rd(OFF_SPINS, v);       check("e_spins", v, 32'h0);
        rd(agree_offset(1), v); check("e_agree1", v, 32'h0);
        rd(OFF_STATUS, v);      check("e_status", v, 32'h0);

        // Run F: a normal run after reset completes with the default RUN_CYCLES of 0.
        run(0, 0, 32'd0);
        check_timing("f", 0);
        check_results(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
